serv_ram_arbiter: RTL and testbench
===================================

Name: serv_ram_arbiter

Overview:
Shares one single-port, byte-enabled synchronous RAM macro between three requesters: the SERV instruction bus, the SERV data bus and an external byte-wide host/loader port. A small FSM owns arbitration, RAM sequencing, byte-lane steering and ack generation. Data width, RAM depth and RAM read latency are parameters. Sits between serv_top and the RAM macro in the top-level wrapper.

Parameters:
AW, 5, RAM word-address width (depth = 2**AW words)
DW, 32, data width in bits; multiple of 8; LB = log2(DW/8) byte-offset bits
RD_LAT, 1, RAM read latency in cycles; legal range 1..4, anything else is an elaboration error
HOST_PRIO, 1, 1: host beats both SERV buses; 0: host has lowest priority

Ports:
clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
i_ibus_cyc  in  1  SERV instruction read request; held until ack
i_ibus_adr  in  AW+LB  instruction byte address
o_ibus_rdt  out  DW  instruction read data; valid while o_ibus_ack=1
o_ibus_ack  out  1  one-cycle acknowledge
i_dbus_cyc  in  1  SERV data request; held until ack
i_dbus_adr  in  AW+LB  data byte address
i_dbus_we  in  1  1 = write
i_dbus_dat  in  DW  write data
i_dbus_sel  in  DW/8  byte enables
o_dbus_rdt  out  DW  read data; valid with ack
o_dbus_ack  out  1  one-cycle acknowledge
i_host_req  in  1  host byte request; level, held until ack
i_host_we  in  1  1 = write
i_host_adr  in  AW+LB  host byte address
i_host_dat  in  8  host write byte
o_host_rdt  out  8  host read byte; valid with ack
o_host_ack  out  1  one-cycle acknowledge
o_ram_en  out  1  RAM enable
o_ram_a  out  AW  RAM word address
o_ram_we  out  DW/8  RAM byte write enables
o_ram_di  out  DW  RAM write data
i_ram_do  in  DW  RAM read data, valid RD_LAT cycles after the enabled edge
o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: async to IDLE. All outputs 0, including the rdt registers. Reset during any state aborts the transaction with no ack.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is high, latch the winner's address, we, data, sel and grant ID, then go to ISSUE.
  - Priority with HOST_PRIO=1: host > dbus > ibus.
  - Priority with HOST_PRIO=0: dbus > ibus > host.
- ISSUE (exactly 1 cycle): o_ram_en=1, o_ram_a = latched adr[AW+LB-1:LB].
  - Write: o_ram_we and o_ram_di driven as below, next state ACK.
  - Read: o_ram_we=0, next state WAIT.
- WAIT: lasts RD_LAT cycles, counted by a down-counter. On the last WAIT cycle, register i_ram_do into the granted master's rdt register, then go to ACK.
- ACK (1 cycle): granted master's ack=1 only if its cyc/req is still high. Next state IDLE.
  - If cyc/req has dropped, no ack is issued and the transaction is discarded. A write already performed in ISSUE is not undone.
- o_ram_en, o_ram_we and o_ram_di are 0 outside ISSUE.
- Latency from the request-seen cycle T:
  - Read: ack at T+2+RD_LAT.
  - Write: ack at T+2.
  - Back-to-back: the next grant is evaluated in the IDLE cycle after ACK.
- Requesters must drop cyc/req in the cycle after ack (SERV does this natively). A request still high in IDLE is treated as a new transaction.
- dbus steering:
  - Writes: o_ram_we = i_dbus_sel, o_ram_di = i_dbus_dat. Address low LB bits are ignored.
  - Reads: return the full word.
- ibus: always a read; the full word is returned.
- host steering:
  - lane = adr[LB-1:0].
  - Write: o_ram_we = one-hot(lane), o_ram_di = i_host_dat replicated DW/8 times.
  - Read: o_host_rdt = captured word byte[lane].
- rdt registers hold their value until that master's next read capture.
- Addresses wrap: only the low AW+LB bits are used.

Decomposition:
- Package serv_ram_pkg: FSM state enum, grant ID enum (GNT_NONE/IBUS/DBUS/HOST), and an LB helper function.
- Sub-module serv_ram_lane_steer: combinational host byte-lane write mask, write-data replication and read-byte extraction, parametrised by DW.

Test Plan:
(All scenarios use DW=32, AW=5, RD_LAT=1 unless stated.)
1. Reset: assert i_rst during a WAIT of a dbus read -> next sample shows all outputs 0, o_busy=0, no ack after release.
2. Host byte load then word read:
   - Stimulus: host writes 0x11, 0x22, 0x33, 0x44 to byte addrs 0..3.
   - Required: o_ram_we = 0001, 0010, 0100, 1000 and o_ram_di = 0x11111111 for the first byte; each host ack at T+2.
   - Then: dbus read at addr 0 -> o_dbus_rdt=0x44332211 with ack at T+3.
3. Contention, HOST_PRIO=1:
   - Stimulus: host read and ibus_cyc both rise at T.
   - Required: host ack at T+3; ibus ISSUE at T+5 and ibus ack at T+7; never both acks in one cycle.
4. Masked write:
   - Stimulus: dbus write adr=0x08, sel=0110, dat=0xAABBCCDD over word 2 = 0x00000000.
   - Required: o_ram_a=2, o_ram_we=0110, ack T+2; dbus readback = 0x00BBCC00.
5. RD_LAT=2 build, and address wrap:
   - ibus read -> ack at T+4.
   - Host read of byte adr 0x81 (wraps to word 0, lane 1) -> o_host_rdt = byte1 of word 0.
6. Abandon: ibus_cyc dropped during WAIT -> no o_ibus_ack, o_busy falls after the ACK cycle, next request serviced normally.

Source files
------------

// File: rtl/serv_ram_pkg.sv
// Shared types and helpers for the SERV RAM arbiter: FSM states, grant IDs
// and byte-offset width helpers.
package serv_ram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IBUS = 2'd1,
        GNT_DBUS = 2'd2,
        GNT_HOST = 2'd3
    } gnt_t;

    // Byte-offset bits within one RAM word.
    function automatic int lb_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Lane index width, kept at least 1 so single-byte words still elaborate.
    function automatic int lane_w(input int dw);
        return (lb_bits(dw) > 0) ? lb_bits(dw) : 1;
    endfunction

endpackage

// File: rtl/serv_ram_arbiter_if.sv
// Bundle of the three requester buses, the RAM macro port and the busy flag.
interface serv_ram_arbiter_if import serv_ram_pkg::*; #(
    parameter int AW = 5,
    parameter int DW = 32
) ();
    localparam int LB = lb_bits(DW);
    localparam int NB = DW / 8;

    logic              i_ibus_cyc;
    logic [AW+LB-1:0]  i_ibus_adr;
    logic [DW-1:0]     o_ibus_rdt;
    logic              o_ibus_ack;

    logic              i_dbus_cyc;
    logic [AW+LB-1:0]  i_dbus_adr;
    logic              i_dbus_we;
    logic [DW-1:0]     i_dbus_dat;
    logic [NB-1:0]     i_dbus_sel;
    logic [DW-1:0]     o_dbus_rdt;
    logic              o_dbus_ack;

    logic              i_host_req;
    logic              i_host_we;
    logic [AW+LB-1:0]  i_host_adr;
    logic [7:0]        i_host_dat;
    logic [7:0]        o_host_rdt;
    logic              o_host_ack;

    logic              o_ram_en;
    logic [AW-1:0]     o_ram_a;
    logic [NB-1:0]     o_ram_we;
    logic [DW-1:0]     o_ram_di;
    logic [DW-1:0]     i_ram_do;

    logic              o_busy;

    modport slave (
        input  i_ibus_cyc, i_ibus_adr,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
        output o_dbus_rdt, o_dbus_ack,
        input  i_host_req, i_host_we, i_host_adr, i_host_dat,
        output o_host_rdt, o_host_ack,
        output o_ram_en, o_ram_a, o_ram_we, o_ram_di,
        input  i_ram_do,
        output o_busy
    );

    modport master (
        output i_ibus_cyc, i_ibus_adr,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
        input  o_dbus_rdt, o_dbus_ack,
        output i_host_req, i_host_we, i_host_adr, i_host_dat,
        input  o_host_rdt, o_host_ack,
        input  o_ram_en, o_ram_a, o_ram_we, o_ram_di,
        output i_ram_do,
        input  o_busy
    );

endinterface

// File: rtl/serv_ram_lane_steer.sv
// Host byte-lane steering: one-hot write mask, byte replication across the
// word for writes, and byte extraction from a read word.
module serv_ram_lane_steer import serv_ram_pkg::*; #(
    parameter int DW = 32,
    parameter int LW = lane_w(DW)
) (
    input  logic [LW-1:0]   lane,
    input  logic [7:0]      wbyte,
    input  logic [DW-1:0]   rword,
    output logic [DW/8-1:0] mask,
    output logic [DW-1:0]   wword,
    output logic [7:0]      rbyte
);
    always_comb begin
        mask       = '0;
        mask[lane] = 1'b1;
        wword      = {(DW/8){wbyte}};
        rbyte      = rword[8*int'(lane) +: 8];
    end
endmodule

// File: rtl/serv_ram_arbiter.sv
// Arbitrates SERV ibus, SERV dbus and a byte-wide host port onto one
// single-port byte-enabled synchronous RAM.
module serv_ram_arbiter import serv_ram_pkg::*; #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int HOST_PRIO = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    serv_ram_arbiter_if.slave  bus
);
    localparam int LB = lb_bits(DW);
    localparam int NB = DW / 8;
    localparam int LW = lane_w(DW);

    if (RD_LAT < 1 || RD_LAT > 4 || (DW % 8) != 0) begin : g_param_err
        $error("serv_ram_arbiter: RD_LAT must be 1..4 and DW a multiple of 8");
    end

    state_t            state, state_nxt;
    gnt_t              gnt, win;
    logic [1:0]        cnt;
    logic [AW+LB-1:0]  lat_adr;
    logic              lat_we;
    logic [DW-1:0]     lat_dat;
    logic [NB-1:0]     lat_sel;
    logic [LW-1:0]     lane;
    logic [NB-1:0]     host_mask;
    logic [DW-1:0]     host_word;
    logic [7:0]        host_byte;
    logic              issue, capture;

    if (LB > 0) begin : g_lane
        assign lane = lat_adr[LW-1:0];
    end else begin : g_no_lane
        assign lane = '0;
    end

    serv_ram_lane_steer #(.DW(DW), .LW(LW)) u_steer (
        .lane  (lane),
        .wbyte (lat_dat[7:0]),
        .rword (bus.i_ram_do),
        .mask  (host_mask),
        .wword (host_word),
        .rbyte (host_byte)
    );

    always_comb begin
        win = GNT_NONE;
        if (HOST_PRIO != 0) begin
            if (bus.i_host_req)      win = GNT_HOST;
            else if (bus.i_dbus_cyc) win = GNT_DBUS;
            else if (bus.i_ibus_cyc) win = GNT_IBUS;
        end else begin
            if (bus.i_dbus_cyc)      win = GNT_DBUS;
            else if (bus.i_ibus_cyc) win = GNT_IBUS;
            else if (bus.i_host_req) win = GNT_HOST;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win != GNT_NONE) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_ACK : S_WAIT;
            S_WAIT:  if (cnt == 2'd0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign issue   = (state == S_ISSUE);
    assign capture = (state == S_WAIT) && (cnt == 2'd0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            gnt            <= GNT_NONE;
            cnt            <= 2'd0;
            bus.o_ibus_rdt <= '0;
            bus.o_dbus_rdt <= '0;
            bus.o_host_rdt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) gnt <= win;
            if (issue)                        cnt <= 2'(RD_LAT - 1);
            else if (state == S_WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
            if (capture) begin
                case (gnt)
                    GNT_IBUS: bus.o_ibus_rdt <= bus.i_ram_do;
                    GNT_DBUS: bus.o_dbus_rdt <= bus.i_ram_do;
                    GNT_HOST: bus.o_host_rdt <= host_byte;
                    default:  ;
                endcase
            end
        end
    end

    // Request payload is only consumed while the grant is live, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            case (win)
                GNT_HOST: begin
                    lat_adr <= bus.i_host_adr;
                    lat_we  <= bus.i_host_we;
                    lat_dat <= DW'(bus.i_host_dat);
                    lat_sel <= '0;
                end
                GNT_DBUS: begin
                    lat_adr <= bus.i_dbus_adr;
                    lat_we  <= bus.i_dbus_we;
                    lat_dat <= bus.i_dbus_dat;
                    lat_sel <= bus.i_dbus_sel;
                end
                GNT_IBUS: begin
                    lat_adr <= bus.i_ibus_adr;
                    lat_we  <= 1'b0;
                    lat_dat <= '0;
                    lat_sel <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ram_en = issue;
    assign bus.o_ram_a  = issue ? lat_adr[AW+LB-1:LB] : '0;
    assign bus.o_ram_we = (issue && lat_we) ? ((gnt == GNT_HOST) ? host_mask : lat_sel) : '0;
    assign bus.o_ram_di = (issue && lat_we) ? ((gnt == GNT_HOST) ? host_word : lat_dat) : '0;
    assign bus.o_busy   = (state != S_IDLE);

    // Acks are withheld when the requester has already given up.
    assign bus.o_ibus_ack = (state == S_ACK) && (gnt == GNT_IBUS) && bus.i_ibus_cyc;
    assign bus.o_dbus_ack = (state == S_ACK) && (gnt == GNT_DBUS) && bus.i_dbus_cyc;
    assign bus.o_host_ack = (state == S_ACK) && (gnt == GNT_HOST) && bus.i_host_req;

endmodule

// File: tb/tb_serv_ram_arbiter.sv
// Directed bench for serv_ram_arbiter: RD_LAT=1 instance for the main scenarios,
// RD_LAT=2 instance for latency and address-wrap checks.
module tb_serv_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serv_ram_arbiter_if #(.AW(5), .DW(32)) if1 ();
    serv_ram_arbiter_if #(.AW(5), .DW(32)) if2 ();

    serv_ram_arbiter #(.AW(5), .DW(32), .RD_LAT(1), .HOST_PRIO(1)) dut1 (
        .clk(clk), .i_rst(rst), .bus(if1));
    serv_ram_arbiter #(.AW(5), .DW(32), .RD_LAT(2), .HOST_PRIO(1)) dut2 (
        .clk(clk), .i_rst(rst), .bus(if2));

    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] rd1_p0, rd2_p0, rd2_p1;

    // RAM models: one-cycle and two-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= 32'h0;
                mem2[i] <= (i == 0) ? 32'h44332211 : 32'h0;
            end
        end else begin
            if (if1.o_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (if1.o_ram_we[b]) mem1[if1.o_ram_a][8*b +: 8] <= if1.o_ram_di[8*b +: 8];
                rd1_p0 <= mem1[if1.o_ram_a];
            end
            if (if2.o_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (if2.o_ram_we[b]) mem2[if2.o_ram_a][8*b +: 8] <= if2.o_ram_di[8*b +: 8];
                rd2_p0 <= mem2[if2.o_ram_a];
            end
        end
        rd2_p1 <= rd2_p0;
    end
    assign if1.i_ram_do = rd1_p0;
    assign if2.i_ram_do = rd2_p1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d,
                              input logic [3:0] we_exp, input logic [31:0] di_exp);
        if1.i_host_req = 1'b1; if1.i_host_we = 1'b1; if1.i_host_adr = a; if1.i_host_dat = d;
        tick();
        chk("hw_en", 32'(if1.o_ram_en), 32'd1);
        chk("hw_we", 32'(if1.o_ram_we), 32'(we_exp));
        chk("hw_di", if1.o_ram_di, di_exp);
        chk("hw_ack_early", 32'(if1.o_host_ack), 32'd0);
        tick();
        chk("hw_ack", 32'(if1.o_host_ack), 32'd1);
        tick();
        if1.i_host_req = 1'b0; if1.i_host_we = 1'b0;
        chk("hw_idle", 32'(if1.o_busy), 32'd0);
    endtask

    task automatic dbus_read(input logic [6:0] a, input logic [31:0] exp);
        if1.i_dbus_cyc = 1'b1; if1.i_dbus_we = 1'b0; if1.i_dbus_adr = a;
        tick();
        chk("dr_en", 32'(if1.o_ram_en), 32'd1);
        chk("dr_we", 32'(if1.o_ram_we), 32'd0);
        chk("dr_a", 32'(if1.o_ram_a), 32'(a[6:2]));
        tick();
        chk("dr_ack_early", 32'(if1.o_dbus_ack), 32'd0);
        tick();
        chk("dr_ack", 32'(if1.o_dbus_ack), 32'd1);
        chk("dr_rdt", if1.o_dbus_rdt, exp);
        tick();
        if1.i_dbus_cyc = 1'b0;
    endtask

    task automatic dbus_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] sel,
                              input logic [4:0] a_exp);
        if1.i_dbus_cyc = 1'b1; if1.i_dbus_we = 1'b1; if1.i_dbus_adr = a;
        if1.i_dbus_dat = d; if1.i_dbus_sel = sel;
        tick();
        chk("dw_a", 32'(if1.o_ram_a), 32'(a_exp));
        chk("dw_we", 32'(if1.o_ram_we), 32'(sel));
        chk("dw_di", if1.o_ram_di, d);
        tick();
        chk("dw_ack", 32'(if1.o_dbus_ack), 32'd1);
        tick();
        if1.i_dbus_cyc = 1'b0; if1.i_dbus_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a81;
        a81 = 8'h81;
        if1.i_ibus_cyc = 0; if1.i_ibus_adr = '0;
        if1.i_dbus_cyc = 0; if1.i_dbus_adr = '0; if1.i_dbus_we = 0; if1.i_dbus_dat = '0; if1.i_dbus_sel = '0;
        if1.i_host_req = 0; if1.i_host_we = 0; if1.i_host_adr = '0; if1.i_host_dat = '0;
        if2.i_ibus_cyc = 0; if2.i_ibus_adr = '0;
        if2.i_dbus_cyc = 0; if2.i_dbus_adr = '0; if2.i_dbus_we = 0; if2.i_dbus_dat = '0; if2.i_dbus_sel = '0;
        if2.i_host_req = 0; if2.i_host_we = 0; if2.i_host_adr = '0; if2.i_host_dat = '0;

        tick();
        tick();
        mem_clr = 1'b0;
        chk("rst_busy", 32'(if1.o_busy), 32'd0);
        chk("rst_en", 32'(if1.o_ram_en), 32'd0);
        chk("rst_dbus_rdt", if1.o_dbus_rdt, 32'd0);
        chk("rst_busy2", 32'(if2.o_busy), 32'd0);
        rst = 1'b0;
        tick();

        // Host byte load, then word readback through dbus.
        host_write(7'd0, 8'h11, 4'b0001, 32'h11111111);
        host_write(7'd1, 8'h22, 4'b0010, 32'h22222222);
        host_write(7'd2, 8'h33, 4'b0100, 32'h33333333);
        host_write(7'd3, 8'h44, 4'b1000, 32'h44444444);
        dbus_read(7'd0, 32'h44332211);

        // Masked write into word 2, then readback.
        dbus_write(7'h08, 32'hAABBCCDD, 4'b0110, 5'd2);
        dbus_read(7'h08, 32'h00BBCC00);

        // Host read and ibus contend; host wins.
        if1.i_host_req = 1'b1; if1.i_host_we = 1'b0; if1.i_host_adr = 7'h09;
        if1.i_ibus_cyc = 1'b1; if1.i_ibus_adr = 7'h00;
        tick();
        chk("ct_a_host", 32'(if1.o_ram_a), 32'd2);
        tick();
        chk("ct_both_t2", 32'(if1.o_host_ack | if1.o_ibus_ack), 32'd0);
        tick();
        chk("ct_host_ack", 32'(if1.o_host_ack), 32'd1);
        chk("ct_ibus_ack_t3", 32'(if1.o_ibus_ack), 32'd0);
        chk("ct_host_rdt", 32'(if1.o_host_rdt), 32'h0000_00CC);
        tick();
        if1.i_host_req = 1'b0;
        chk("ct_en_t4", 32'(if1.o_ram_en), 32'd0);
        tick();
        chk("ct_en_t5", 32'(if1.o_ram_en), 32'd1);
        chk("ct_a_ibus", 32'(if1.o_ram_a), 32'd0);
        tick();
        chk("ct_ibus_ack_t6", 32'(if1.o_ibus_ack), 32'd0);
        tick();
        chk("ct_ibus_ack", 32'(if1.o_ibus_ack), 32'd1);
        chk("ct_host_ack_t7", 32'(if1.o_host_ack), 32'd0);
        chk("ct_ibus_rdt", if1.o_ibus_rdt, 32'h44332211);
        tick();
        if1.i_ibus_cyc = 1'b0;

        // Reset in the middle of a dbus read.
        if1.i_dbus_cyc = 1'b1; if1.i_dbus_we = 1'b0; if1.i_dbus_adr = 7'd0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(if1.o_busy), 32'd0);
        chk("ar_en", 32'(if1.o_ram_en), 32'd0);
        chk("ar_dbus_rdt", if1.o_dbus_rdt, 32'd0);
        chk("ar_ibus_rdt", if1.o_ibus_rdt, 32'd0);
        chk("ar_host_rdt", 32'(if1.o_host_rdt), 32'd0);
        chk("ar_ack", 32'(if1.o_dbus_ack), 32'd0);
        if1.i_dbus_cyc = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_ack", 32'(if1.o_dbus_ack), 32'd0);
        end

        // ibus abandons during WAIT, then a fresh read is serviced.
        if1.i_ibus_cyc = 1'b1; if1.i_ibus_adr = 7'h08;
        tick();
        tick();
        if1.i_ibus_cyc = 1'b0;
        tick();
        chk("ab_no_ack", 32'(if1.o_ibus_ack), 32'd0);
        chk("ab_busy_ack", 32'(if1.o_busy), 32'd1);
        tick();
        chk("ab_busy_idle", 32'(if1.o_busy), 32'd0);
        if1.i_ibus_cyc = 1'b1; if1.i_ibus_adr = 7'h00;
        tick();
        tick();
        tick();
        chk("ab_next_ack", 32'(if1.o_ibus_ack), 32'd1);
        chk("ab_next_rdt", if1.o_ibus_rdt, 32'h44332211);
        tick();
        if1.i_ibus_cyc = 1'b0;

        // RD_LAT=2: ibus latency and wrapped host byte address.
        if2.i_ibus_cyc = 1'b1; if2.i_ibus_adr = 7'h00;
        tick();
        chk("l2_en", 32'(if2.o_ram_en), 32'd1);
        tick();
        tick();
        chk("l2_ack_t3", 32'(if2.o_ibus_ack), 32'd0);
        tick();
        chk("l2_ack", 32'(if2.o_ibus_ack), 32'd1);
        chk("l2_rdt", if2.o_ibus_rdt, 32'h44332211);
        tick();
        if2.i_ibus_cyc = 1'b0;
        if2.i_host_req = 1'b1; if2.i_host_we = 1'b0; if2.i_host_adr = a81[6:0];
        tick();
        chk("wr_a", 32'(if2.o_ram_a), 32'd0);
        tick();
        tick();
        chk("wr_ack_t3", 32'(if2.o_host_ack), 32'd0);
        tick();
        chk("wr_ack", 32'(if2.o_host_ack), 32'd1);
        chk("wr_rdt", 32'(if2.o_host_rdt), 32'h0000_0022);
        tick();
        if2.i_host_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
